// File: rtl/seg_pkg.sv
// Shared types and constants for the time-multiplexed 7-segment scanner.
package seg_pkg;

   localparam logic [8:0] ZERO_PAT = 9'h03f;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      DRIVE
   } state_e;

   // Idle level of a single segment or digit-enable line: high when that line is active-low.
   function automatic logic seg_off(input bit act_low);
      return act_low;
   endfunction

   function automatic logic dig_off(input bit act_low);
      return act_low;
   endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Pattern inputs, controls and display outputs of the scanner.
interface seg_scan_mux_if #(
   parameter int NUM_DIGITS = 2,
   parameter int SEG_W      = 9
);
   logic [NUM_DIGITS*SEG_W-1:0] seg_in;
   logic                        en;
   logic [3:0]                  bright;
   logic                        lz_blank;
   logic [SEG_W-1:0]            seg_out;
   logic [NUM_DIGITS-1:0]       dig_sel;
   logic                        frame_tick;

   modport master (
      output seg_in, en, bright, lz_blank,
      input  seg_out, dig_sel, frame_tick
   );

   modport slave (
      input  seg_in, en, bright, lz_blank,
      output seg_out, dig_sel, frame_tick
   );
endinterface

// File: rtl/seg_scan_timer.sv
// Slot/digit timebase: counts clocks within a digit slot, steps the digit index
// and flags the last cycle of every slot and of every frame.
module seg_scan_timer #(
   parameter int SCAN_DIV   = 12000,
   parameter int NUM_DIGITS = 2,
   parameter int SLOT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1,
   parameter int DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              run_i,
   output logic [SLOT_W-1:0] slot_cnt_o,
   output logic [DIG_W-1:0]  digit_o,
   output logic              slot_end_o,
   output logic              frame_end_o
);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [DIG_W-1:0]  digit_q, digit_d;
   logic              slot_end;

   assign slot_end = run_i && (slot_q == SLOT_LAST);

   always_comb begin
      slot_d  = slot_q;
      digit_d = digit_q;
      if (clear_i) begin
         slot_d  = '0;
         digit_d = '0;
      end else if (slot_end) begin
         slot_d  = '0;
         digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
      end else if (run_i) begin
         slot_d = slot_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_q  <= '0;
         digit_q <= '0;
      end else begin
         slot_q  <= slot_d;
         digit_q <= digit_d;
      end
   end

   assign slot_cnt_o  = slot_q;
   assign digit_o     = digit_q;
   assign slot_end_o  = slot_end;
   assign frame_end_o = slot_end && (digit_q == DIG_LAST);

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment driver: per-frame snapshot, dead time between digits,
// 16-level brightness PWM and leading-zero blanking, all outputs registered.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 2,
   parameter int SEG_W       = 9,
   parameter int SCAN_DIV    = 12000,
   parameter int BLANK_CYC   = 120,
   parameter bit SEG_ACT_LOW = 1'b0,
   parameter bit DIG_ACT_LOW = 1'b1
) (
   input logic           clk,
   input logic           rst,
   seg_scan_mux_if.slave bus
);
   localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [SLOT_W-1:0]     BLANK_LAST = SLOT_W'(BLANK_CYC - 1);
   localparam logic [SEG_W-1:0]      ZERO_LOC   = SEG_W'(ZERO_PAT);
   localparam logic [SEG_W-1:0]      SEG_IDLE   = {SEG_W{seg_off(SEG_ACT_LOW)}};
   localparam logic [NUM_DIGITS-1:0] DIG_IDLE   = {NUM_DIGITS{dig_off(DIG_ACT_LOW)}};

   state_e state_q, state_d;

   logic [SLOT_W-1:0] slot_cnt;
   logic [DIG_W-1:0]  digit;
   logic              slot_end, frame_end;
   logic              tmr_clear, tmr_run;

   logic [NUM_DIGITS-1:0][SEG_W-1:0] snap_q, snap_d;
   logic                             snap_load;
   logic [3:0]                       pwm_q, pwm_d;

   logic [NUM_DIGITS-1:0] digit_hot;
   logic [NUM_DIGITS-1:0] lz_mask;
   logic                  zero_run;
   logic [SEG_W-1:0]      cur_pat;

   logic [SEG_W-1:0]      seg_q, seg_d;
   logic [NUM_DIGITS-1:0] dig_q, dig_d;
   logic                  tick_q, tick_d;

   // The timebase sits at zero whenever the display is idle so every start is aligned to digit 0.
   assign tmr_clear = !bus.en || (state_q == IDLE);
   assign tmr_run   = bus.en && (state_q != IDLE);

   seg_scan_timer #(
      .SCAN_DIV   (SCAN_DIV),
      .NUM_DIGITS (NUM_DIGITS),
      .SLOT_W     (SLOT_W),
      .DIG_W      (DIG_W)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (tmr_clear),
      .run_i       (tmr_run),
      .slot_cnt_o  (slot_cnt),
      .digit_o     (digit),
      .slot_end_o  (slot_end),
      .frame_end_o (frame_end)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.en) state_d = BLANK;
         BLANK:   if (!bus.en) state_d = IDLE;
                  else if (slot_cnt == BLANK_LAST) state_d = DRIVE;
         DRIVE:   if (!bus.en) state_d = IDLE;
                  else if (slot_end) state_d = BLANK;
         default: state_d = IDLE;
      endcase
   end

   assign snap_load = bus.en && ((state_q == IDLE) || frame_end);
   assign snap_d    = snap_load ? bus.seg_in : snap_q;
   assign pwm_d     = pwm_q + 4'd1;

   genvar gi;
   for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_hot[gi] = (digit == DIG_W'(gi));
   end

   // A digit is blanked only while it and every more-significant digit show zero.
   always_comb begin
      lz_mask  = '0;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run   = zero_run && (snap_q[i] == ZERO_LOC);
         lz_mask[i] = bus.lz_blank && zero_run;
      end
   end

   assign cur_pat = snap_q[digit];

   // PWM-off cycles keep the pattern on the bus; only the digit enable is gated.
   always_comb begin
      seg_d  = SEG_IDLE;
      dig_d  = DIG_IDLE;
      tick_d = frame_end;
      if (bus.en && (state_q == DRIVE) && !lz_mask[digit]) begin
         seg_d = cur_pat ^ {SEG_W{SEG_ACT_LOW}};
         if (pwm_q <= bus.bright) begin
            dig_d = digit_hot ^ {NUM_DIGITS{DIG_ACT_LOW}};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         snap_q  <= '0;
         pwm_q   <= '0;
         seg_q   <= SEG_IDLE;
         dig_q   <= DIG_IDLE;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         pwm_q   <= pwm_d;
         seg_q   <= seg_d;
         dig_q   <= dig_d;
         tick_q  <= tick_d;
      end
   end

   assign bus.seg_out    = seg_q;
   assign bus.dig_sel    = dig_q;
   assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: frame-position reference model plus directed scan, snapshot,
// blanking, PWM and enable scenarios on a short-slot and a long-slot instance.
module tb_seg_scan_mux;
   localparam int ND = 2;
   localparam int SW = 9;
   localparam int SD = 8;
   localparam int BC = 2;
   localparam int SD_B = 40;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   seg_scan_mux_if #(.NUM_DIGITS(ND), .SEG_W(SW)) bus_a ();
   seg_scan_mux_if #(.NUM_DIGITS(ND), .SEG_W(SW)) bus_b ();

   seg_scan_mux #(
      .NUM_DIGITS(ND), .SEG_W(SW), .SCAN_DIV(SD), .BLANK_CYC(BC),
      .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b1)
   ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

   seg_scan_mux #(
      .NUM_DIGITS(ND), .SEG_W(SW), .SCAN_DIV(SD_B), .BLANK_CYC(BC),
      .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b1)
   ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   // Reference model for dut_a: position t within the frame, snapshot and PWM phase.
   logic [SW-1:0] m_snap [ND];
   bit            m_active;
   int            m_t;
   int            m_pwm;
   logic [SW-1:0] exp_seg;
   logic [ND-1:0] exp_dig;
   logic          exp_tick;

   always @(posedge clk or negedge rst) begin
      int  d;
      int  s;
      bit  blank;
      if (!rst) begin
         m_active = 1'b0;
         m_t      = 0;
         m_pwm    = 0;
         for (int j = 0; j < ND; j++) m_snap[j] = '0;
         exp_seg  = '0;
         exp_dig  = '1;
         exp_tick = 1'b0;
      end else begin
         exp_seg  = '0;
         exp_dig  = '1;
         exp_tick = 1'b0;
         if (bus_a.en && m_active) begin
            d = m_t / SD;
            s = m_t % SD;
            if (s >= BC) begin
               blank = bus_a.lz_blank && (d != 0);
               for (int j = d; j < ND; j++) if (m_snap[j] != 9'h03f) blank = 1'b0;
               if (!blank) begin
                  exp_seg = m_snap[d];
                  if (m_pwm <= int'(bus_a.bright)) exp_dig[d] = 1'b0;
               end
            end
            exp_tick = (m_t == ND * SD - 1);
         end
         m_pwm = (m_pwm + 1) % 16;
         if (!bus_a.en) begin
            m_active = 1'b0;
         end else if (!m_active || m_t == ND * SD - 1) begin
            m_active = 1'b1;
            m_t      = 0;
            for (int j = 0; j < ND; j++) m_snap[j] = bus_a.seg_in[j*SW +: SW];
         end else begin
            m_t = m_t + 1;
         end
      end
   end

   task automatic test_reset();
      rst = 1'b0;
      bus_a.en = 1'b1;
      bus_a.seg_in = {9'h006, 9'h05b};
      bus_a.bright = 4'd15;
      bus_a.lz_blank = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if ({bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick} !== {9'h000, 2'b11, 1'b0}) begin
            bad++;
            $display("FAIL reset cyc=%0d got seg=%h dig=%b tick=%b exp seg=000 dig=11 tick=0",
                     i, bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick);
         end
      end
   endtask

   task automatic test_basic_scan();
      rst = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         total++;
         if ({bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick} !== {exp_seg, exp_dig, exp_tick}) begin
            bad++;
            $display("FAIL basic_model k=%0d got=%h exp=%h", k,
                     {bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick}, {exp_seg, exp_dig, exp_tick});
         end
         if (k == 3 || k == 4 || k == 17) begin
            total++;
            if (k == 3 && {bus_a.seg_out, bus_a.dig_sel} !== {9'h000, 2'b11}) begin
               bad++;
               $display("FAIL basic_blank got seg=%h dig=%b exp seg=000 dig=11", bus_a.seg_out, bus_a.dig_sel);
            end
            if (k == 4 && {bus_a.seg_out, bus_a.dig_sel} !== {9'h05b, 2'b10}) begin
               bad++;
               $display("FAIL basic_digit0 got seg=%h dig=%b exp seg=05b dig=10", bus_a.seg_out, bus_a.dig_sel);
            end
            if (k == 17 && {bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick} !== {9'h006, 2'b01, 1'b1}) begin
               bad++;
               $display("FAIL basic_tick got seg=%h dig=%b tick=%b exp seg=006 dig=01 tick=1",
                        bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick);
            end
         end
      end
   endtask

   task automatic test_snapshot();
      logic [SW-1:0] want;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         total++;
         if ({bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick} !== {exp_seg, exp_dig, exp_tick}) begin
            bad++;
            $display("FAIL snap_model i=%0d got=%h exp=%h", i,
                     {bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick}, {exp_seg, exp_dig, exp_tick});
         end
         if (i == 13 || i == 18 || i == 26) begin
            want = (i == 13) ? 9'h006 : (i == 18) ? 9'h066 : 9'h04f;
            total++;
            if (bus_a.seg_out !== want) begin
               bad++;
               $display("FAIL snap_frame i=%0d got seg=%h exp seg=%h", i, bus_a.seg_out, want);
            end
         end
         if (i == 10) bus_a.seg_in = {9'h04f, 9'h066};
      end
   endtask

   task automatic test_lz_blank();
      int c0;
      int c1;
      bus_a.seg_in = {9'h03f, 9'h03f};
      for (int pass = 0; pass < 2; pass++) begin
         bus_a.lz_blank = (pass == 0);
         c0 = 0;
         c1 = 0;
         for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            total++;
            if ({bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick} !== {exp_seg, exp_dig, exp_tick}) begin
               bad++;
               $display("FAIL lz_model pass=%0d i=%0d got=%h exp=%h", pass, i,
                        {bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick}, {exp_seg, exp_dig, exp_tick});
            end
            if (i >= 32 && bus_a.dig_sel === 2'b10) c0++;
            if (i >= 32 && bus_a.dig_sel === 2'b01) c1++;
         end
         total++;
         if (c0 != 12 || c1 != (pass == 0 ? 0 : 12)) begin
            bad++;
            $display("FAIL lz_count pass=%0d got d0=%0d d1=%0d exp d0=12 d1=%0d",
                     pass, c0, c1, (pass == 0 ? 0 : 12));
         end
      end
   endtask

   task automatic test_en_drop();
      bit found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (exp_dig != 2'b11) begin
            found = 1'b1;
            break;
         end
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL en_drop_wait got no DRIVE cycle within 40 cycles exp one");
      end
      bus_a.en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if ({bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick} !== {9'h000, 2'b11, 1'b0}) begin
            bad++;
            $display("FAIL en_off i=%0d got seg=%h dig=%b tick=%b exp seg=000 dig=11 tick=0",
                     i, bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick);
         end
      end
      bus_a.en = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         total++;
         if ({bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick} !== {exp_seg, exp_dig, exp_tick}) begin
            bad++;
            $display("FAIL en_restart k=%0d got=%h exp=%h", k,
                     {bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick}, {exp_seg, exp_dig, exp_tick});
         end
         if (k == 3 || k == 4) begin
            total++;
            if ((k == 3 && bus_a.dig_sel !== 2'b11) ||
                (k == 4 && {bus_a.seg_out, bus_a.dig_sel} !== {bus_a.seg_in[SW-1:0], 2'b10})) begin
               bad++;
               $display("FAIL en_restart_digit0 k=%0d got seg=%h dig=%b", k, bus_a.seg_out, bus_a.dig_sel);
            end
         end
      end
   endtask

   task automatic test_pwm();
      int cnt;
      bit in_win;
      logic [SW-1:0] pat;
      logic [ND-1:0] on_val;
      bus_b.seg_in = {9'h04f, 9'h066};
      bus_b.lz_blank = 1'b0;
      for (int pass = 0; pass < 2; pass++) begin
         bus_b.bright = (pass == 0) ? 4'd3 : 4'($urandom_range(0, 15));
         bus_b.en = 1'b0;
         @(negedge clk);
         bus_b.en = 1'b1;
         cnt = 0;
         for (int k = 1; k <= 77; k++) begin
            @(negedge clk);
            in_win = (k >= 4 && k <= 19) || (k >= 22 && k <= 37) ||
                     (k >= 44 && k <= 59) || (k >= 62 && k <= 77);
            if (in_win) begin
               pat    = (k < 42) ? 9'h066 : 9'h04f;
               on_val = (k < 42) ? 2'b10 : 2'b01;
               total++;
               if (bus_b.seg_out !== pat || !(bus_b.dig_sel === on_val || bus_b.dig_sel === 2'b11)) begin
                  bad++;
                  $display("FAIL pwm_cycle k=%0d got seg=%h dig=%b exp seg=%h dig=%b or 11",
                           k, bus_b.seg_out, bus_b.dig_sel, pat, on_val);
               end
               if (bus_b.dig_sel === on_val) cnt++;
               if (k == 19 || k == 37 || k == 59 || k == 77) begin
                  total++;
                  if (cnt != int'(bus_b.bright) + 1) begin
                     bad++;
                     $display("FAIL pwm_duty k=%0d bright=%0d got on=%0d exp on=%0d",
                              k, bus_b.bright, cnt, int'(bus_b.bright) + 1);
                  end
                  cnt = 0;
               end
            end
         end
      end
      bus_b.en = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         total++;
         if ({bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick} !== {exp_seg, exp_dig, exp_tick}) begin
            bad++;
            $display("FAIL rand_model i=%0d in=%h br=%0d lz=%b en=%b got=%h exp=%h", i, bus_a.seg_in,
                     bus_a.bright, bus_a.lz_blank, bus_a.en,
                     {bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick}, {exp_seg, exp_dig, exp_tick});
         end
         if ($urandom_range(0, 11) == 0) begin
            for (int j = 0; j < ND; j++)
               bus_a.seg_in[j*SW +: SW] = ($urandom_range(0, 2) == 0) ? 9'h03f : 9'($urandom);
         end
         if ($urandom_range(0, 29) == 0) bus_a.bright = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) bus_a.lz_blank = ~bus_a.lz_blank;
         if (bus_a.en && $urandom_range(0, 59) == 0) bus_a.en = 1'b0;
         else if (!bus_a.en && $urandom_range(0, 3) == 0) bus_a.en = 1'b1;
      end
   endtask

   task automatic test_async_reset();
      bus_a.en = 1'b1;
      bus_a.bright = 4'd15;
      bus_a.seg_in = {9'h07d, 9'h06d};
      repeat (12) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      total++;
      if ({bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick} !== {9'h000, 2'b11, 1'b0}) begin
         bad++;
         $display("FAIL async_reset got seg=%h dig=%b tick=%b exp seg=000 dig=11 tick=0",
                  bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         total++;
         if ({bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick} !== {exp_seg, exp_dig, exp_tick}) begin
            bad++;
            $display("FAIL post_reset k=%0d got=%h exp=%h", k,
                     {bus_a.seg_out, bus_a.dig_sel, bus_a.frame_tick}, {exp_seg, exp_dig, exp_tick});
         end
      end
   endtask

   initial begin
      bus_b.seg_in = '0;
      bus_b.en = 1'b0;
      bus_b.bright = 4'd0;
      bus_b.lz_blank = 1'b0;
      test_reset();
      test_basic_scan();
      test_snapshot();
      test_lz_blank();
      test_en_drop();
      test_pwm();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
